l1_prefetch_receiver: RTL and testbench

//  Consumer end of the L1 prefetcher request channel (valid/ready, addr, write).

---
 rtl/l1_prefetch_pkg.sv | 19 +
 rtl/l1_pf_entry_cam.sv | 71 +++++++
 rtl/l1_prefetch_receiver.sv | 146 ++++++++++++++
 tb/tb_l1_prefetch_receiver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/l1_prefetch_pkg.sv
// Shared types and helpers for the L1 prefetch receiver slice.
// Default geometry: 40-bit byte addresses, 64-byte lines.
package l1_prefetch_pkg;

  localparam int unsigned PF_ADDR_BITS  = 40;
  localparam int unsigned PF_LINE_SHIFT = 6;
  localparam int unsigned LINE_BITS     = PF_ADDR_BITS - PF_LINE_SHIFT;

  typedef struct packed {
    logic [LINE_BITS-1:0] line;
    logic                 write;
    logic                 valid;
  } pf_entry_t;

  function automatic logic [LINE_BITS-1:0] line_of(input logic [PF_ADDR_BITS-1:0] addr);
    return addr[PF_ADDR_BITS-1:PF_LINE_SHIFT];
  endfunction

endpackage

// File: rtl/l1_pf_entry_cam.sv
// Queue storage for pending prefetch lines. Entries are written at the tail
// and read at the head. Two match ports (accept and snoop) compare only against valid entries.
module l1_pf_entry_cam
  import l1_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LINE_W = LINE_BITS,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_idx,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              wr_write,
  input  logic [PTR_W-1:0]  rd_idx,
  output logic [LINE_W-1:0] rd_line,
  output logic              rd_write,
  output logic              rd_valid,
  input  logic              clr_en,
  input  logic [LINE_W-1:0] acc_line,
  output logic [DEPTH-1:0]  acc_hit,
  output logic              acc_hit_write,
  input  logic [LINE_W-1:0] snp_line,
  output logic [DEPTH-1:0]  snp_hit,
  input  logic [DEPTH-1:0]  inval,
  input  logic [DEPTH-1:0]  upgrade
);

  logic [LINE_W-1:0] line_q [DEPTH];
  logic [DEPTH-1:0]  write_q;
  logic [DEPTH-1:0]  valid_q;

  assign rd_line  = line_q[rd_idx];
  assign rd_write = write_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];

  always_comb begin
    acc_hit       = '0;
    snp_hit       = '0;
    acc_hit_write = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      acc_hit[i]    = valid_q[i] && (line_q[i] == acc_line);
      snp_hit[i]    = valid_q[i] && (line_q[i] == snp_line);
      acc_hit_write = acc_hit_write | (acc_hit[i] & write_q[i]);
    end
  end

  // The tail slot is never valid when written, so push cannot collide with
  // invalidate/upgrade strobes, which only target valid entries.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      write_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_en && (wr_idx == PTR_W'(i))) begin
          line_q[i]  <= wr_line;
          write_q[i] <= wr_write;
          valid_q[i] <= 1'b1;
        end else begin
          if (inval[i] || (clr_en && (rd_idx == PTR_W'(i))))
            valid_q[i] <= 1'b0;
          if (upgrade[i])
            write_q[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/l1_prefetch_receiver.sv
// Receives prefetch hints, deduplicates them by cache line and squashes them against demand
// traffic. Survivors are queued and issued to the L1 miss path under an in-flight limit.
module l1_prefetch_receiver
  import l1_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = PF_ADDR_BITS,
  parameter int unsigned LINE_SHIFT   = PF_LINE_SHIFT,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter int unsigned CNT_BITS     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pf_valid,
  output logic                 pf_ready,
  input  logic [ADDR_BITS-1:0] pf_bits_addr,
  input  logic                 pf_bits_write,
  input  logic                 cpu_req_valid,
  input  logic [ADDR_BITS-1:0] cpu_req_bits_addr,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ADDR_BITS-1:0] mem_req_bits_addr,
  output logic                 mem_req_bits_write,
  input  logic                 mem_resp_valid,
  output logic [CNT_BITS-1:0]  drop_count
);

  localparam int unsigned LB    = ADDR_BITS - LINE_SHIFT;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned IF_W  = $clog2(MAX_INFLIGHT + 2);

  logic [PTR_W-1:0]  head, tail;
  logic [OCC_W-1:0]  occupancy;
  logic              out_valid, out_write;
  logic [LB-1:0]     out_line;
  logic [IF_W-1:0]   inflight;
  logic [CNT_BITS-1:0] drop_q;

  logic [LB-1:0]     pf_line, cpu_line, rd_line;
  logic              rd_write, rd_valid;
  logic [DEPTH-1:0]  acc_hit, snp_hit, inval, upgrade;
  logic              acc_hit_write;

  logic full, pf_fire, mem_fire, q_hit, out_hit, cpu_hit, upgrade_any;
  logic acc_drop, snoop_drop, push, occ_nz, slot_free, issue_ok, discard, load, pop;
  logic [CNT_BITS:0] drop_sum;

  assign pf_line  = pf_bits_addr[ADDR_BITS-1:LINE_SHIFT];
  assign cpu_line = cpu_req_bits_addr[ADDR_BITS-1:LINE_SHIFT];

  assign full     = (occupancy == OCC_W'(DEPTH));
  assign pf_ready = !reset && !full;
  assign pf_fire  = pf_valid && pf_ready;
  assign mem_fire = out_valid && mem_req_ready;

  l1_pf_entry_cam #(
    .DEPTH  (DEPTH),
    .LINE_W (LB)
  ) u_cam (
    .clock         (clock),
    .reset         (reset),
    .wr_en         (push),
    .wr_idx        (tail),
    .wr_line       (pf_line),
    .wr_write      (pf_bits_write),
    .rd_idx        (head),
    .rd_line       (rd_line),
    .rd_write      (rd_write),
    .rd_valid      (rd_valid),
    .clr_en        (pop),
    .acc_line      (pf_line),
    .acc_hit       (acc_hit),
    .acc_hit_write (acc_hit_write),
    .snp_line      (cpu_line),
    .snp_hit       (snp_hit),
    .inval         (inval),
    .upgrade       (upgrade)
  );

  always_comb begin
    q_hit       = |acc_hit;
    out_hit     = out_valid && (out_line == pf_line);
    cpu_hit     = cpu_req_valid && (cpu_line == pf_line);
    upgrade_any = pf_fire && q_hit && pf_bits_write && !acc_hit_write;
    upgrade     = upgrade_any ? acc_hit : '0;
    acc_drop    = pf_fire && ((q_hit && !upgrade_any) || (!q_hit && (out_hit || cpu_hit)));
    push        = pf_fire && !q_hit && !out_hit && !cpu_hit;
    inval       = cpu_req_valid ? snp_hit : '0;
    snoop_drop  = |inval;
  end

  // The output register counts as a committed slot, so reloading it while it
  // fires can never push inflight past MAX_INFLIGHT.
  always_comb begin
    occ_nz    = (occupancy != '0);
    slot_free = !out_valid || mem_fire;
    issue_ok  = (32'(inflight) + 32'(out_valid)) < 32'(MAX_INFLIGHT);
    discard   = occ_nz && !rd_valid;
    load      = occ_nz && rd_valid && !inval[head] && slot_free && issue_ok;
    pop       = discard || load;
    drop_sum  = {1'b0, drop_q} + (CNT_BITS+1)'(acc_drop) + (CNT_BITS+1)'(snoop_drop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      out_valid <= 1'b0;
      out_write <= 1'b0;
      out_line  <= '0;
      inflight  <= '0;
      drop_q    <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)
        occupancy <= occupancy + OCC_W'(1);
      else if (!push && pop)
        occupancy <= occupancy - OCC_W'(1);

      // A write upgrade landing on the head as it moves out must not be lost.
      if (load) begin
        out_valid <= 1'b1;
        out_line  <= rd_line;
        out_write <= rd_write | upgrade[head];
      end else if (mem_fire) begin
        out_valid <= 1'b0;
      end

      if (mem_fire && !mem_resp_valid)
        inflight <= inflight + IF_W'(1);
      else if (!mem_fire && mem_resp_valid && (inflight != '0))
        inflight <= inflight - IF_W'(1);

      drop_q <= drop_sum[CNT_BITS] ? '1 : drop_sum[CNT_BITS-1:0];
    end
  end

  assign mem_req_valid      = out_valid;
  assign mem_req_bits_addr  = {out_line, {LINE_SHIFT{1'b0}}};
  assign mem_req_bits_write = out_write;
  assign drop_count         = drop_q;

endmodule

// File: tb/tb_l1_prefetch_receiver.sv
// Directed bench for l1_prefetch_receiver: linear steps with hand-computed expectations.
module tb_l1_prefetch_receiver;

  logic        clock = 1'b0;
  logic        reset;
  logic        pf_valid;
  logic        pf_ready;
  logic [39:0] pf_bits_addr;
  logic        pf_bits_write;
  logic        cpu_req_valid;
  logic [39:0] cpu_req_bits_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [39:0] mem_req_bits_addr;
  logic        mem_req_bits_write;
  logic        mem_resp_valid;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  l1_prefetch_receiver #(
    .ADDR_BITS    (40),
    .LINE_SHIFT   (6),
    .DEPTH        (4),
    .MAX_INFLIGHT (2),
    .CNT_BITS     (16)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .pf_valid           (pf_valid),
    .pf_ready           (pf_ready),
    .pf_bits_addr       (pf_bits_addr),
    .pf_bits_write      (pf_bits_write),
    .cpu_req_valid      (cpu_req_valid),
    .cpu_req_bits_addr  (cpu_req_bits_addr),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_bits_addr  (mem_req_bits_addr),
    .mem_req_bits_write (mem_req_bits_write),
    .mem_resp_valid     (mem_resp_valid),
    .drop_count         (drop_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    pf_valid = 1'b0;
    pf_bits_addr = '0;
    pf_bits_write = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_bits_addr = '0;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;

    step();
    step();
    check("rst_pf_ready", 64'(pf_ready), 64'd0);
    check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_pf_ready", 64'(pf_ready), 64'd1);

    // Single hint, two-cycle latency, response clears inflight
    pf_valid = 1'b1; pf_bits_addr = 40'h00_1000_0047; pf_bits_write = 1'b0;
    step();
    pf_valid = 1'b0;
    check("t1_t1_valid", 64'(mem_req_valid), 64'd0);
    step();
    check("t1_t2_valid", 64'(mem_req_valid), 64'd1);
    check("t1_t2_addr", 64'(mem_req_bits_addr), 64'h00_1000_0040);
    check("t1_t2_write", 64'(mem_req_bits_write), 64'd0);
    step();
    check("t1_after_fire_valid", 64'(mem_req_valid), 64'd0);
    check("t1_inflight_1", 64'(dut.inflight), 64'd1);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    check("t1_inflight_0", 64'(dut.inflight), 64'd0);

    // Three hints on one line: queue-match drop, then output-register drop
    pf_valid = 1'b1; pf_bits_addr = 40'h2000;
    step();
    pf_bits_addr = 40'h2010;
    step();
    check("t2_valid", 64'(mem_req_valid), 64'd1);
    check("t2_addr", 64'(mem_req_bits_addr), 64'h2000);
    pf_bits_addr = 40'h2020;
    step();
    pf_valid = 1'b0;
    check("t2_drop", 64'(drop_count), 64'd2);
    check("t2_single_issue", 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;

    // Read hint upgraded to write by a later hint on the same line
    pf_valid = 1'b1; pf_bits_addr = 40'h3000; pf_bits_write = 1'b0;
    step();
    pf_bits_addr = 40'h3008; pf_bits_write = 1'b1;
    step();
    pf_valid = 1'b0; pf_bits_write = 1'b0;
    check("t3_valid", 64'(mem_req_valid), 64'd1);
    check("t3_addr", 64'(mem_req_bits_addr), 64'h3000);
    check("t3_write", 64'(mem_req_bits_write), 64'd1);
    step();
    check("t3_drop_unchanged", 64'(drop_count), 64'd2);
    check("t3_single_issue", 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;

    // Demand snoop squashes a queued line; the output register survives
    mem_req_ready = 1'b0;
    pf_valid = 1'b1; pf_bits_addr = 40'h4000;
    step();
    pf_bits_addr = 40'h4040;
    step();
    pf_valid = 1'b0;
    cpu_req_valid = 1'b1; cpu_req_bits_addr = 40'h4044;
    check("t4_out_valid", 64'(mem_req_valid), 64'd1);
    check("t4_out_addr", 64'(mem_req_bits_addr), 64'h4000);
    step();
    cpu_req_valid = 1'b0;
    check("t4_drop", 64'(drop_count), 64'd3);
    mem_req_ready = 1'b1;
    step();
    check("t4_no_second_issue", 64'(mem_req_valid), 64'd0);
    check("t4_occupancy", 64'(dut.occupancy), 64'd0);
    check("t4_inflight", 64'(dut.inflight), 64'd1);
    step();
    check("t4_still_idle", 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    check("t4_inflight_0", 64'(dut.inflight), 64'd0);

    // Fill: one in the output register plus DEPTH queued, then inflight cap
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pf_valid = 1'b1;
      pf_bits_addr = 40'h5000 + 40'(i) * 40'h40;
      check("t5_pf_ready_open", 64'(pf_ready), 64'd1);
      if (i >= 2) check("t5_addr_stable", 64'(mem_req_bits_addr), 64'h5000);
      step();
    end
    check("t5_pf_ready_full", 64'(pf_ready), 64'd0);
    check("t5_valid_held", 64'(mem_req_valid), 64'd1);
    check("t5_addr_held", 64'(mem_req_bits_addr), 64'h5000);
    pf_bits_addr = 40'h5140;
    step();
    pf_valid = 1'b0;
    check("t5_no_accept_when_full", 64'(dut.occupancy), 64'd4);
    check("t5_drop_unchanged", 64'(drop_count), 64'd3);
    mem_req_ready = 1'b1;
    step();
    check("t5_second_valid", 64'(mem_req_valid), 64'd1);
    check("t5_second_addr", 64'(mem_req_bits_addr), 64'h5040);
    check("t5_inflight_1", 64'(dut.inflight), 64'd1);
    step();
    check("t5_capped_valid", 64'(mem_req_valid), 64'd0);
    check("t5_inflight_2", 64'(dut.inflight), 64'd2);
    step();
    check("t5_cap_holds", 64'(mem_req_valid), 64'd0);
    check("t5_inflight_still_2", 64'(dut.inflight), 64'd2);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    check("t5_inflight_after_resp", 64'(dut.inflight), 64'd1);
    check("t5_occupancy_3", 64'(dut.occupancy), 64'd3);

    // Reset mid-stream
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("t6_mem_valid", 64'(mem_req_valid), 64'd0);
    check("t6_drop", 64'(drop_count), 64'd0);
    check("t6_pf_ready", 64'(pf_ready), 64'd1);
    check("t6_inflight", 64'(dut.inflight), 64'd0);
    check("t6_occupancy", 64'(dut.occupancy), 64'd0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    check("t6_resp_ignored", 64'(dut.inflight), 64'd0);
    check("t6_still_idle", 64'(mem_req_valid), 64'd0);

    // Same-cycle hint and demand on one line with nothing queued
    mem_req_ready = 1'b1;
    pf_valid = 1'b1; pf_bits_addr = 40'h6000;
    cpu_req_valid = 1'b1; cpu_req_bits_addr = 40'h6010;
    step();
    pf_valid = 1'b0; cpu_req_valid = 1'b0;
    check("t7_drop", 64'(drop_count), 64'd1);
    check("t7_no_push", 64'(dut.occupancy), 64'd0);
    step();
    check("t7_no_issue", 64'(mem_req_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
